// File: rtl/fifo_pkg.sv
// Shared pointer helpers for the async FIFO write and read controllers.
// Combinational only: no latency and no backpressure.
package fifo_pkg;

  localparam int DEFAULT_ADDR_WIDTH = 4;
  // Widest pointer the helpers handle (ADDR_WIDTH up to 12, plus the wrap bit).
  localparam int MAX_PTR_W = 13;

  function automatic logic [MAX_PTR_W-1:0] bin2gray(input logic [MAX_PTR_W-1:0] bin);
    return bin ^ (bin >> 1);
  endfunction

  // Narrower pointers are zero-extended, so the prefix XOR from the top
  // leaves their low bits correct.
  function automatic logic [MAX_PTR_W-1:0] gray2bin(input logic [MAX_PTR_W-1:0] gray);
    logic [MAX_PTR_W-1:0] bin;
    bin = '0;
    bin[MAX_PTR_W-1] = gray[MAX_PTR_W-1];
    for (int i = MAX_PTR_W - 2; i >= 0; i--) begin
      bin[i] = bin[i+1] ^ gray[i];
    end
    return bin;
  endfunction

endpackage

// File: rtl/fifo_sync_2ff.sv
// Two-flop synchronizer for a Gray-coded pointer crossing into clk.
// Latency: 2 clk edges from d_dat to q_dat; no backpressure.
module fifo_sync_2ff #(
  parameter int WIDTH = 5
) (
  input  logic             clk,
  input  logic             arst_n,
  input  logic [WIDTH-1:0] d_dat,
  output logic [WIDTH-1:0] q_dat
);

  logic [WIDTH-1:0] sync_q1;

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      sync_q1 <= '0;
      q_dat   <= '0;
    end else begin
      sync_q1 <= d_dat;
      q_dat   <= sync_q1;
    end
  end

endmodule

// File: rtl/async_fifo_wr_ctrl.sv
// Async FIFO write-side pointer/flag controller; wclken is combinational, wfull registered.
// Writes while full are dropped and flagged in sticky woverflow; read pointer seen 2 edges late.
module async_fifo_wr_ctrl
  import fifo_pkg::*;
#(
  parameter int ADDR_WIDTH  = DEFAULT_ADDR_WIDTH,
  parameter int AFULL_LEVEL = 12
) (
  input  logic                  w_clk,
  input  logic                  w_rst,
  input  logic                  winc,
  input  logic [ADDR_WIDTH:0]   rptr_gray,
  input  logic                  wovf_clr,
  output logic                  wclken,
  output logic [ADDR_WIDTH-1:0] waddr,
  output logic [ADDR_WIDTH:0]   wptr_gray,
  output logic                  wfull,
  output logic                  walmost_full,
  output logic [ADDR_WIDTH:0]   wlevel,
  output logic                  woverflow
);

  localparam int PW = ADDR_WIDTH + 1;
  localparam logic [PW-1:0] AFULL_THR = PW'(AFULL_LEVEL);

  logic [PW-1:0] wbin;
  logic [PW-1:0] wbin_next;
  logic [PW-1:0] wgray_next;
  logic [PW-1:0] rq2;
  logic [PW-1:0] rq2_bin;
  logic [PW-1:0] full_gray;
  logic          accept;

  fifo_sync_2ff #(
    .WIDTH (PW)
  ) u_rptr_sync (
    .clk    (w_clk),
    .arst_n (w_rst),
    .d_dat  (rptr_gray),
    .q_dat  (rq2)
  );

  assign accept     = winc & ~wfull;
  assign wclken     = accept;
  assign wbin_next  = wbin + PW'(accept);
  assign wgray_next = PW'(bin2gray(MAX_PTR_W'(wbin_next)));

  // Full when the write pointer is exactly one lap ahead: in Gray code the
  // two top bits differ and the rest match.
  assign full_gray  = {~rq2[PW-1:PW-2], rq2[PW-3:0]};

  assign rq2_bin      = PW'(gray2bin(MAX_PTR_W'(rq2)));
  assign wlevel       = wbin - rq2_bin;
  assign walmost_full = (wlevel >= AFULL_THR);
  assign waddr        = wbin[ADDR_WIDTH-1:0];

  always_ff @(posedge w_clk or negedge w_rst) begin
    if (!w_rst) begin
      wbin      <= '0;
      wptr_gray <= '0;
      wfull     <= 1'b0;
      woverflow <= 1'b0;
    end else begin
      wbin      <= wbin_next;
      wptr_gray <= wgray_next;
      wfull     <= (wgray_next == full_gray);
      woverflow <= (winc & wfull) | (woverflow & ~wovf_clr);
    end
  end

  a_gray_one_bit: assert property (@(posedge w_clk) disable iff (!w_rst)
    $countones(wptr_gray ^ $past(wptr_gray)) <= 1);

  a_level_bound: assert property (@(posedge w_clk) disable iff (!w_rst)
    wlevel <= PW'(1 << ADDR_WIDTH));

endmodule

// File: tb/tb_async_fifo_wr_ctrl.sv
// Randomized + directed bench for async_fifo_wr_ctrl against a count-based reference model.
module tb_async_fifo_wr_ctrl;

  localparam int AW    = 4;
  localparam int PW    = AW + 1;
  localparam int DEPTH = 1 << AW;
  localparam int LAP   = 1 << PW;
  localparam int AFL   = 12;

  logic          w_clk = 1'b0;
  logic          w_rst;
  logic          winc;
  logic [PW-1:0] rptr_gray;
  logic          wovf_clr;
  logic          wclken;
  logic [AW-1:0] waddr;
  logic [PW-1:0] wptr_gray;
  logic          wfull;
  logic          walmost_full;
  logic [PW-1:0] wlevel;
  logic          woverflow;

  always #5 w_clk = ~w_clk;

  async_fifo_wr_ctrl #(
    .ADDR_WIDTH  (AW),
    .AFULL_LEVEL (AFL)
  ) dut (
    .w_clk        (w_clk),
    .w_rst        (w_rst),
    .winc         (winc),
    .rptr_gray    (rptr_gray),
    .wovf_clr     (wovf_clr),
    .wclken       (wclken),
    .waddr        (waddr),
    .wptr_gray    (wptr_gray),
    .wfull        (wfull),
    .walmost_full (walmost_full),
    .wlevel       (wlevel),
    .woverflow    (woverflow)
  );

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model: counts of writes, the read count as the writer sees it
  // two edges late, and the flags.
  int m_w, m_rq1, m_rq2, rb;
  bit m_full, m_ovf;
  bit gray_chk;
  bit ever_full;
  logic [PW-1:0] prev_gray;

  function automatic logic [PW-1:0] to_gray(input int b);
    logic [PW-1:0] v;
    v = PW'(b);
    return v ^ (v >> 1);
  endfunction

  function automatic int m_level();
    return (m_w - m_rq2 + LAP) % LAP;
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_all(input string ph);
    check_eq({ph, ".waddr"},     32'(waddr),        32'(m_w % DEPTH));
    check_eq({ph, ".wptr_gray"}, 32'(wptr_gray),    32'(to_gray(m_w)));
    check_eq({ph, ".wlevel"},    32'(wlevel),       32'(m_level()));
    check_eq({ph, ".wfull"},     32'(wfull),        32'(m_full));
    check_eq({ph, ".afull"},     32'(walmost_full), 32'(m_level() >= AFL));
    check_eq({ph, ".wovf"},      32'(woverflow),    32'(m_ovf));
  endtask

  task automatic model_reset();
    m_w = 0; m_rq1 = 0; m_rq2 = 0; rb = 0;
    m_full = 1'b0; m_ovf = 1'b0;
  endtask

  task automatic cycle(input string ph, input bit wi, input bit clr, input bit adv);
    bit acc;
    int new_w;
    winc     = wi;
    wovf_clr = clr;
    if (adv && rb != m_w) rb = (rb + 1) % LAP;
    rptr_gray = to_gray(rb);
    #1;
    check_eq({ph, ".wclken"}, 32'(wclken), 32'(wi && !m_full));
    @(posedge w_clk);
    acc    = wi && !m_full;
    m_ovf  = (wi && m_full) ? 1'b1 : (clr ? 1'b0 : m_ovf);
    new_w  = (m_w + int'(acc)) % LAP;
    // Full is judged against the read count visible before this edge.
    m_full = ((new_w - m_rq2 + LAP) % LAP) == DEPTH;
    m_rq2  = m_rq1;
    m_rq1  = rb;
    m_w    = new_w;
    #1;
    check_all(ph);
    if (gray_chk) check_eq({ph, ".gray1bit"}, 32'($countones(wptr_gray ^ prev_gray) <= 1), 32'd1);
    if (wfull) ever_full = 1'b1;
    prev_gray = wptr_gray;
  endtask

  task automatic do_reset();
    w_rst = 1'b0; winc = 1'b0; wovf_clr = 1'b0; rptr_gray = '0;
    model_reset();
    #1;
    check_eq("rst.wclken", 32'(wclken), 32'd0);
    check_all("rst");
    repeat (2) @(posedge w_clk);
    #1;
    w_rst = 1'b1;
    prev_gray = '0;
  endtask

  initial begin
    gray_chk = 1'b0;
    ever_full = 1'b0;
    do_reset();

    // Fill from empty; first write lands on the first edge after release.
    for (int i = 1; i <= DEPTH; i++) begin
      cycle("fill", 1'b1, 1'b0, 1'b0);
      check_eq("fill.afull_edge", 32'(walmost_full), 32'(i >= AFL));
    end
    check_eq("fill.full",  32'(wfull),     32'd1);
    check_eq("fill.level", 32'(wlevel),    32'd16);
    check_eq("fill.gray",  32'(wptr_gray), 32'b11000);

    // Overflow set, clear, and set-wins-over-clear.
    cycle("ovf", 1'b1, 1'b0, 1'b0);
    check_eq("ovf.set",   32'(woverflow), 32'd1);
    check_eq("ovf.waddr", 32'(waddr),     32'd0);
    cycle("ovfclr", 1'b0, 1'b1, 1'b0);
    check_eq("ovf.clr", 32'(woverflow), 32'd0);
    cycle("ovfboth", 1'b1, 1'b1, 1'b0);
    check_eq("ovf.setwins", 32'(woverflow), 32'd1);
    cycle("ovfclr2", 1'b0, 1'b1, 1'b0);

    // One read: level drops after 2 edges, full releases on the 3rd.
    cycle("rd1", 1'b0, 1'b0, 1'b1);
    check_eq("rd1.full", 32'(wfull), 32'd1);
    cycle("rd2", 1'b0, 1'b0, 1'b0);
    check_eq("rd2.level", 32'(wlevel), 32'd15);
    check_eq("rd2.full",  32'(wfull),  32'd1);
    cycle("rd3", 1'b0, 1'b0, 1'b0);
    check_eq("rd3.full", 32'(wfull), 32'd0);

    // Streaming with the reader keeping pace.
    do_reset();
    gray_chk  = 1'b1;
    ever_full = 1'b0;
    for (int i = 0; i < 40; i++) cycle("stream", 1'b1, 1'b0, 1'b1);
    check_eq("stream.waddr",     32'(waddr),     32'd8);
    check_eq("stream.gray",      32'(wptr_gray), 32'b01100);
    check_eq("stream.neverfull", 32'(ever_full), 32'd0);

    // Random traffic, writer-heavy so full and overflow are exercised.
    for (int i = 0; i < 600; i++) begin
      cycle("rand", ($urandom % 4) != 0, ($urandom % 8) == 0, ($urandom % 3) == 0);
    end

    // Asynchronous reset mid-cycle with data outstanding.
    do_reset();
    for (int i = 0; i < 7; i++) cycle("pre", 1'b1, 1'b0, 1'b0);
    cycle("pre", 1'b0, 1'b0, 1'b0);
    check_eq("pre.level", 32'(wlevel), 32'd7);
    winc = 1'b0;
    #2;
    w_rst = 1'b0;
    model_reset();
    #1;
    check_eq("arst.wclken", 32'(wclken), 32'd0);
    check_all("arst");
    repeat (2) @(posedge w_clk);
    #1;
    w_rst = 1'b1;
    prev_gray = '0;
    cycle("post", 1'b1, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
